// File: rtl/collatz_pkg.sv
// rtl/collatz_pkg.sv - shared widths, mode codes and state encoding for the collatz engine
package collatz_pkg;

   localparam int DEFAULT_BUS_WIDTH   = 8;
   localparam int DEFAULT_STEPS_WIDTH = 8;

   localparam logic MODE_STANDARD = 1'b0;
   localparam logic MODE_SHORTCUT = 1'b1;

   typedef logic [2:0] state_t;

   localparam state_t STATE_IDLE  = 3'd0;
   localparam state_t STATE_CHECK = 3'd1;
   localparam state_t STATE_EVEN  = 3'd2;
   localparam state_t STATE_ODD   = 3'd3;
   localparam state_t STATE_DONE  = 3'd4;

endpackage

// File: rtl/collatz_alu.sv
// rtl/collatz_alu.sv - combinational next-n, parity and overflow for both step modes
module collatz_alu
   import collatz_pkg::*;
#(
   parameter int DATAWIDTH_BUS = DEFAULT_BUS_WIDTH
) (
   input  logic [DATAWIDTH_BUS-1:0] n,
   input  logic                     mode,
   output logic [DATAWIDTH_BUS-1:0] evenResult,
   output logic [DATAWIDTH_BUS-1:0] oddResult,
   output logic                     isOdd,
   output logic                     overflow
);

   localparam int WIDE = DATAWIDTH_BUS + 2;

   logic [WIDE-1:0] tripled;
   logic [WIDE-1:0] oddWide;

   // 3n+1 of the largest n still fits in two extra bits, so overflow is just the top bits
   always_comb begin
      tripled    = {1'b0, n, 1'b0} + {2'b00, n} + WIDE'(1);
      oddWide    = (mode == MODE_SHORTCUT) ? (tripled >> 1) : tripled;
      overflow   = |oddWide[WIDE-1:DATAWIDTH_BUS];
      oddResult  = oddWide[DATAWIDTH_BUS-1:0];
      evenResult = n >> 1;
      isOdd      = n[0];
   end

endmodule

// File: rtl/collatz_engine.sv
// rtl/collatz_engine.sv - Collatz sequence runner with step count, peak tracking and termination flags
module collatz_engine
   import collatz_pkg::*;
#(
   parameter int DATAWIDTH_BUS   = DEFAULT_BUS_WIDTH,
   parameter int DATAWIDTH_STEPS = DEFAULT_STEPS_WIDTH
) (
   input  logic                       COLLATZ_ENGINE_CLOCK_50,
   input  logic                       COLLATZ_ENGINE_RESET_InLow,
   input  logic                       COLLATZ_ENGINE_start_InHigh,
   input  logic                       COLLATZ_ENGINE_ack_InHigh,
   input  logic                       COLLATZ_ENGINE_mode_InHigh,
   input  logic [DATAWIDTH_BUS-1:0]   COLLATZ_ENGINE_seed_InBUS,
   output logic [DATAWIDTH_BUS-1:0]   COLLATZ_ENGINE_value_OutBUS,
   output logic [DATAWIDTH_STEPS-1:0] COLLATZ_ENGINE_steps_OutBUS,
   output logic [DATAWIDTH_BUS-1:0]   COLLATZ_ENGINE_peak_OutBUS,
   output logic                       COLLATZ_ENGINE_busy_OutHigh,
   output logic                       COLLATZ_ENGINE_done_OutHigh,
   output logic                       COLLATZ_ENGINE_overflow_OutHigh,
   output logic                       COLLATZ_ENGINE_saturated_OutHigh,
   output logic                       COLLATZ_ENGINE_zeroseed_OutHigh
);

   localparam logic [DATAWIDTH_STEPS-1:0] STEPS_MAX = '1;
   localparam logic [DATAWIDTH_STEPS-1:0] STEP_ONE  = {{(DATAWIDTH_STEPS-1){1'b0}}, 1'b1};
   localparam logic [DATAWIDTH_BUS-1:0]   N_ONE     = {{(DATAWIDTH_BUS-1){1'b0}}, 1'b1};

   state_t                     state;
   logic [DATAWIDTH_BUS-1:0]   nReg;
   logic [DATAWIDTH_STEPS-1:0] stepsReg;
   logic [DATAWIDTH_BUS-1:0]   peakReg;
   logic                       modeReg;
   logic                       overflowReg;
   logic                       saturatedReg;
   logic                       zeroseedReg;

   logic [DATAWIDTH_BUS-1:0]   evenResult;
   logic [DATAWIDTH_BUS-1:0]   oddResult;
   logic                       isOdd;
   logic                       aluOverflow;
   logic                       accept;

   collatz_alu #(.DATAWIDTH_BUS(DATAWIDTH_BUS)) alu (
      .n          (nReg),
      .mode       (modeReg),
      .evenResult (evenResult),
      .oddResult  (oddResult),
      .isOdd      (isOdd),
      .overflow   (aluOverflow)
   );

   assign accept = COLLATZ_ENGINE_start_InHigh && (state == STATE_IDLE || state == STATE_DONE);

   always_ff @(posedge COLLATZ_ENGINE_CLOCK_50 or negedge COLLATZ_ENGINE_RESET_InLow) begin
      if (!COLLATZ_ENGINE_RESET_InLow) begin
         state        <= STATE_IDLE;
         nReg         <= '0;
         stepsReg     <= '0;
         peakReg      <= '0;
         modeReg      <= MODE_STANDARD;
         overflowReg  <= 1'b0;
         saturatedReg <= 1'b0;
         zeroseedReg  <= 1'b0;
      end else if (accept) begin
         // start takes priority over ack when a result is still being held
         state        <= STATE_CHECK;
         nReg         <= COLLATZ_ENGINE_seed_InBUS;
         peakReg      <= COLLATZ_ENGINE_seed_InBUS;
         stepsReg     <= '0;
         modeReg      <= COLLATZ_ENGINE_mode_InHigh;
         overflowReg  <= 1'b0;
         saturatedReg <= 1'b0;
         zeroseedReg  <= 1'b0;
      end else begin
         case (state)
            STATE_CHECK: begin
               if (nReg == '0) begin
                  state       <= STATE_DONE;
                  zeroseedReg <= 1'b1;
               end else if (nReg == N_ONE) begin
                  state <= STATE_DONE;
               end else if (stepsReg == STEPS_MAX) begin
                  state        <= STATE_DONE;
                  saturatedReg <= 1'b1;
               end else if (isOdd) begin
                  state <= STATE_ODD;
               end else begin
                  state <= STATE_EVEN;
               end
            end
            STATE_EVEN: begin
               nReg     <= evenResult;
               stepsReg <= stepsReg + STEP_ONE;
               state    <= STATE_CHECK;
            end
            STATE_ODD: begin
               if (aluOverflow) begin
                  state       <= STATE_DONE;
                  overflowReg <= 1'b1;
               end else begin
                  nReg     <= oddResult;
                  stepsReg <= stepsReg + STEP_ONE;
                  if (oddResult > peakReg) peakReg <= oddResult;
                  state    <= STATE_CHECK;
               end
            end
            STATE_DONE: begin
               if (COLLATZ_ENGINE_ack_InHigh) state <= STATE_IDLE;
            end
            default: state <= STATE_IDLE;
         endcase
      end
   end

   assign COLLATZ_ENGINE_value_OutBUS      = nReg;
   assign COLLATZ_ENGINE_steps_OutBUS      = stepsReg;
   assign COLLATZ_ENGINE_peak_OutBUS       = peakReg;
   assign COLLATZ_ENGINE_busy_OutHigh      = (state == STATE_CHECK) || (state == STATE_EVEN) || (state == STATE_ODD);
   assign COLLATZ_ENGINE_done_OutHigh      = (state == STATE_DONE);
   assign COLLATZ_ENGINE_overflow_OutHigh  = overflowReg;
   assign COLLATZ_ENGINE_saturated_OutHigh = saturatedReg;
   assign COLLATZ_ENGINE_zeroseed_OutHigh  = zeroseedReg;

endmodule

// File: doc/collatz_engine.md
COLLATZ_ENGINE -- requirements
Module: collatz_engine

Interface
REQ-001 Parameter DATAWIDTH_BUS, 8, width of seed, value and peak.
REQ-002 Parameter DATAWIDTH_STEPS, 8, width of step counter.
REQ-003 COLLATZ_ENGINE_CLOCK_50  in  1  single clock; all state on rising edge.
REQ-004 COLLATZ_ENGINE_RESET_InLow  in  1  reset; asynchronous, active-low.
REQ-005 COLLATZ_ENGINE_start_InHigh  in  1  request a run; sampled in IDLE or DONE only.
REQ-006 COLLATZ_ENGINE_ack_InHigh  in  1  result consumed; DONE -> IDLE.
REQ-007 COLLATZ_ENGINE_mode_InHigh  in  1  0 = standard (3n+1), 1 = shortcut ((3n+1)/2 as one step).
REQ-008 COLLATZ_ENGINE_seed_InBUS  in  DATAWIDTH_BUS  start value.
REQ-009 COLLATZ_ENGINE_value_OutBUS  out  DATAWIDTH_BUS  current/final n.
REQ-010 COLLATZ_ENGINE_steps_OutBUS  out  DATAWIDTH_STEPS  steps taken.
REQ-011 COLLATZ_ENGINE_peak_OutBUS  out  DATAWIDTH_BUS  maximum registered n this run, seed included.
REQ-012 COLLATZ_ENGINE_busy_OutHigh  out  1  high in CHECK, EVEN, ODD.
REQ-013 COLLATZ_ENGINE_done_OutHigh  out  1  high in DONE only.
REQ-014 COLLATZ_ENGINE_overflow_OutHigh, _saturated_OutHigh, _zeroseed_OutHigh  out  1 each  termination cause; valid while done.

Function
REQ-015 States IDLE, CHECK, EVEN, ODD, DONE; registered Moore outputs.
REQ-016 IDLE or DONE with start=1: load n=seed, peak=seed, steps=0, clear flags, latch mode; next CHECK (start wins over ack in DONE).
REQ-017 CHECK: n==0 -> DONE, zeroseed=1; n==1 -> DONE; steps==2^DATAWIDTH_STEPS-1 -> DONE, saturated=1; n even -> EVEN; n odd -> ODD; priority in that order.
REQ-018 EVEN: n=n>>1, steps+1, next CHECK.
REQ-019 ODD: t=3n+1 computed at DATAWIDTH_BUS+2 bits; shortcut mode uses t>>1; result >2^DATAWIDTH_BUS-1 -> DONE, overflow=1, n and steps unchanged; else n=result, steps+1, next CHECK.
REQ-020 Peak updated whenever new n exceeds it; shortcut intermediate t never counted.
REQ-021 Latency: done asserts 2S+1 edges after the accepting edge, S = steps taken.
REQ-022 start while busy ignored; mode/seed changes after acceptance have no effect.
REQ-023 DONE holds all outputs stable until ack (-> IDLE, outputs retained) or start.
REQ-024 At most one termination flag high per run.

Reset
REQ-025 Reset low at any time, including mid-run: state IDLE, all outputs 0, immediately and asynchronously.
REQ-026 Release synchronous to clock edge; first start accepted on the first edge after release.

Structure
REQ-027 Package collatz_pkg holds state enumeration, mode constants and default widths.
REQ-028 Sub-module collatz_alu: combinational next-n, parity, overflow for both modes; FSM, counters and peak register in collatz_engine.

Verification
REQ-029 Seed 6, mode 0 -> steps 8, peak 16, value 1, done 17 edges after acceptance, no flags.
REQ-030 Seed 6, mode 1 -> steps 6, peak 8, value 1, done 13 edges after acceptance.
REQ-031 Seed 1 -> steps 0, peak 1, done after 1 edge; seed 0 -> zeroseed=1, steps 0.
REQ-032 Seed 255, either mode -> overflow=1, value 255, steps 0; seed 27, DATAWIDTH_STEPS=4 -> saturated=1, steps 15.
REQ-033 Reset asserted mid-run of seed 27 -> all outputs 0 same cycle; seed 6 after release reproduces REQ-029; start during busy ignored.
